// File: rtl/mem_mmio.sv
// Memory-mapped subsystem: word RAM, LED register, free-running cycle counter and a byte TX FIFO
// with sticky overflow / bad-address status flags.
module mem_mmio #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [7:0]  led,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   localparam int unsigned RamAw = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0]  FullCount = 4'(FIFO_DEPTH);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

   localparam logic [29:0] LedWord    = 30'h2000_0000;
   localparam logic [29:0] CycleWord  = 30'h2000_0001;
   localparam logic [29:0] TxWord     = 30'h2000_0002;
   localparam logic [29:0] StatusWord = 30'h2000_0003;

   logic [31:0] ram [RAM_WORDS];
   logic [7:0]  fifo_q [FIFO_DEPTH];

   logic [7:0]      led_q, led_d;
   logic [31:0]     cycle_q, cycle_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]      count_q, count_d;
   logic            ovf_q, ovf_d, bad_q, bad_d;

   logic [29:0]      word;
   logic [RamAw-1:0] ram_idx;
   logic             sel_ram, sel_led, sel_cycle, sel_tx, sel_status, sel_none;
   logic             push, pop, push_ok, ovf_set, empty, full;
   logic [31:0]      status;
   logic             unused_adr;

   assign word       = Adr[31:2];
   assign ram_idx    = Adr[RamAw+1:2];
   assign unused_adr = ^Adr[1:0];

   assign sel_ram    = (word < 30'(RAM_WORDS));
   assign sel_led    = (word == LedWord);
   assign sel_cycle  = (word == CycleWord);
   assign sel_tx     = (word == TxWord);
   assign sel_status = (word == StatusWord);
   assign sel_none   = ~(sel_ram | sel_led | sel_cycle | sel_tx | sel_status);

   assign empty    = (count_q == 4'd0);
   assign full     = (count_q == FullCount);
   assign tx_valid = ~empty;
   assign tx_data  = fifo_q[rd_ptr_q];
   assign led      = led_q;
   assign status   = {24'b0, count_q, bad_q, ovf_q, empty, full};

   assign push    = MemWrite & sel_tx;
   assign pop     = tx_valid & tx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + PtrW'(1);
   endfunction

   always_comb begin
      led_d    = led_q;
      cycle_d  = cycle_q + 32'd1;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (MemWrite && sel_led) led_d = WriteData[7:0];
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
      // Set wins over write-1-to-clear.
      ovf_d = (ovf_q & ~(MemWrite & sel_status & WriteData[2])) | ovf_set;
      bad_d = (bad_q & ~(MemWrite & sel_status & WriteData[3])) | (MemWrite & sel_none);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         led_q    <= 8'd0;
         cycle_q  <= 32'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 4'd0;
         ovf_q    <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         led_q    <= led_d;
         cycle_q  <= cycle_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         bad_q    <= bad_d;
      end
   end

   // Storage arrays are not reset; RAM survives reset, FIFO slots are dead once pointers clear.
   always_ff @(posedge clk) begin
      if (reset && MemWrite && sel_ram) ram[ram_idx] <= WriteData;
      if (reset && push_ok) fifo_q[wr_ptr_q] <= WriteData[7:0];
   end

   always_comb begin
      ReadData = 32'd0;
      if (sel_ram)         ReadData = ram[ram_idx];
      else if (sel_led)    ReadData = {24'b0, led_q};
      else if (sel_cycle)  ReadData = cycle_q;
      else if (sel_status) ReadData = status;
   end

endmodule
